// File: rtl/render_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | render_pkg: register map, bit positions and command type shared by   |
// | the renderer command queue.                      Revision: 1.0       |
// +----------------------------------------------------------------------+
package render_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_X      = 4'd1;
    localparam logic [3:0] ADDR_Y      = 4'd2;
    localparam logic [3:0] ADDR_ISSUED = 4'd3;
    localparam logic [3:0] ADDR_CODE   = 4'd4;
    localparam logic [3:0] ADDR_COMMIT = 4'd6;
    localparam logic [3:0] ADDR_CTRL   = 4'd7;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_HOLD_BIT  = 2;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_HOLD_BIT  = 1;

    localparam int CMD_X_W    = 9;
    localparam int CMD_Y_W    = 8;
    localparam int CMD_CODE_W = 8;

    typedef struct packed {
        logic [CMD_X_W-1:0]    x;
        logic [CMD_Y_W-1:0]    y;
        logic [CMD_CODE_W-1:0] code;
    } render_cmd_t;

endpackage
`default_nettype wire

// File: rtl/render_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | render_fifo: first-word-fall-through synchronous FIFO with level     |
// | counter and synchronous flush.                   Revision: 1.0       |
// +----------------------------------------------------------------------+
module render_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q,  level_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Flush wins over any same-cycle push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/render_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | render_cmd_fifo: Avalon-MM staged plot commands queued toward the    |
// | renderer, with hold, flush and progress readback. Revision: 1.0      |
// +----------------------------------------------------------------------+
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int CODE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic              slave_waitrequest,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [X_W-1:0]    cmd_x,
    output logic [Y_W-1:0]    cmd_y,
    output logic [CODE_W-1:0] cmd_code
);

    localparam int CMD_W = X_W + Y_W + CODE_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              hold_q, hold_d;
    logic [15:0]       issued_q, issued_d;

    logic              w_wr_commit;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic [LVL_W-1:0]  w_level;
    logic [CMD_W-1:0]  w_head;
    logic              unused_wdata;

    assign unused_wdata = ^slave_writedata;

    assign w_wr_commit       = slave_write && (slave_address == ADDR_COMMIT);
    assign w_push            = w_wr_commit && !w_full;
    assign w_flush           = slave_write && (slave_address == ADDR_CTRL)
                               && slave_writedata[CTRL_FLUSH_BIT];
    // Depends only on the registered full flag, never on cmd_ready.
    assign slave_waitrequest = w_wr_commit && w_full;

    assign cmd_valid = !w_empty && !hold_q;
    assign w_pop     = cmd_valid && cmd_ready && !w_flush;
    assign {cmd_x, cmd_y, cmd_code} = w_head;

    render_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_flush),
        .push  (w_push),
        .wdata ({x_q, y_q, code_q}),
        .pop   (w_pop),
        .rdata (w_head),
        .empty (w_empty),
        .full  (w_full),
        .level (w_level)
    );

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        code_d   = code_q;
        hold_d   = hold_q;
        issued_d = issued_q + {15'd0, w_pop};
        if (slave_write) begin
            case (slave_address)
                ADDR_X:    x_d    = slave_writedata[X_W-1:0];
                ADDR_Y:    y_d    = slave_writedata[Y_W-1:0];
                ADDR_CODE: code_d = slave_writedata[CODE_W-1:0];
                ADDR_CTRL: hold_d = slave_writedata[CTRL_HOLD_BIT];
                default:   ;
            endcase
        end
    end

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                ADDR_STATUS: begin
                    slave_readdata[STAT_EMPTY_BIT]         = w_empty;
                    slave_readdata[STAT_FULL_BIT]          = w_full;
                    slave_readdata[STAT_HOLD_BIT]          = hold_q;
                    slave_readdata[STAT_LEVEL_LSB +: 8]    = 8'(w_level);
                end
                ADDR_X:      slave_readdata[X_W-1:0]       = x_q;
                ADDR_Y:      slave_readdata[Y_W-1:0]       = y_q;
                ADDR_ISSUED: slave_readdata[15:0]          = issued_q;
                ADDR_CODE:   slave_readdata[CODE_W-1:0]    = code_q;
                ADDR_CTRL:   slave_readdata[CTRL_HOLD_BIT] = hold_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            code_q   <= '0;
            hold_q   <= 1'b0;
            issued_q <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            code_q   <= code_d;
            hold_q   <= hold_d;
            issued_q <= issued_d;
        end
    end

endmodule
`default_nettype wire
